// File: rtl/wt_ctrl_fsm.sv
// wt_ctrl_fsm: write-side controller of the asynchronous FIFO (write clock domain only).
// Accepts push requests, drives the RAM write port, keeps binary/Gray write pointers,
// synchronises the read-domain Gray pointer and derives fill level, full, almost-full
// and a sticky push-on-full error.
//
// Optional build macro: WT_FSM_AFULL_EN
//   defined   -> almost_full_fsm = (DEPTH - wt_count) <= AF_THRESH
//   undefined -> almost_full_fsm tied to 0, AF_THRESH unused
//
// Ports:
//   wt_clk_fsm             in   write clock
//   rst_n_in_wt_fsm        in   asynchronous active-low reset
//   push_in                in   write request, one word per cycle
//   rd_ptr_gray_in         in   Gray read pointer from the read domain [ADDR_W:0]
//   err_clr                in   synchronous clear of the sticky error
//   wt_en_fsm              out  RAM write strobe (same cycle as the accepted push)
//   wt_addr                out  RAM write address [ADDR_W-1:0]
//   wt_ptr_gray            out  registered Gray write pointer [ADDR_W:0]
//   full_fsm               out  FIFO full (registered values only)
//   almost_full_fsm        out  free slots <= AF_THRESH
//   push_on_full_error_fsm out  sticky overflow-attempt flag
//   wt_count               out  write-side fill level 0..DEPTH [ADDR_W:0]
module wt_ctrl_fsm #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned AF_THRESH   = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              wt_clk_fsm,
    input  logic              rst_n_in_wt_fsm,
    input  logic              push_in,
    input  logic [ADDR_W:0]   rd_ptr_gray_in,
    input  logic              err_clr,
    output logic              wt_en_fsm,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W:0]   wt_ptr_gray,
    output logic              full_fsm,
    output logic              almost_full_fsm,
    output logic              push_on_full_error_fsm,
    output logic [ADDR_W:0]   wt_count
);

    localparam int unsigned PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StActive, StFull, StErr} state_e;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic state_e level_state(input logic [PW-1:0] cnt);
        if (cnt == '0) begin
            return StIdle;
        end else if (cnt == DEPTH_V) begin
            return StFull;
        end
        return StActive;
    endfunction

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic          err_q, err_d;
    state_e        state_q, state_d;

    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;
    logic [PW-1:0] count;
    logic [PW-1:0] count_next;
    logic          full;
    logic          accept;

    assign rsync = sync_q[SYNC_STAGES-1];
    assign rbin  = gray2bin(rsync);
    assign count = wbin_q - rbin;

    // Full compares registered pointers only: MSB pair inverted means one lap ahead.
    assign full = (wgray_q == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]});

    // Reset gates the strobe so a write in flight is dropped as soon as reset asserts.
    assign accept = rst_n_in_wt_fsm & push_in & ~full & (state_q != StErr);

    // Fill level after this edge: the last sync stage will take the previous stage's value.
    assign count_next = wbin_d - gray2bin(sync_q[SYNC_STAGES-2]);

    always_comb begin
        wbin_d  = wbin_q;
        wgray_d = wgray_q;
        err_d   = err_q;
        state_d = state_q;

        if (accept) begin
            wbin_d  = wbin_q + 1'b1;
            wgray_d = bin2gray(wbin_q + 1'b1);
        end

        if (state_q == StErr) begin
            if (err_clr) begin
                state_d = level_state(count_next);
                err_d   = 1'b0;
            end
        end else if (push_in && full) begin
            state_d = StErr;
            err_d   = 1'b1;
        end else begin
            state_d = level_state(count_next);
        end
    end

    always_ff @(posedge wt_clk_fsm or negedge rst_n_in_wt_fsm) begin
        if (!rst_n_in_wt_fsm) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            err_q   <= 1'b0;
            state_q <= StIdle;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wbin_q    <= wbin_d;
            wgray_q   <= wgray_d;
            err_q     <= err_d;
            state_q   <= state_d;
            sync_q[0] <= rd_ptr_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wt_en_fsm              = accept;
    assign wt_addr                = wbin_q[ADDR_W-1:0];
    assign wt_ptr_gray            = wgray_q;
    assign full_fsm               = full;
    assign push_on_full_error_fsm = err_q;
    assign wt_count               = count;

`ifdef WT_FSM_AFULL_EN
    localparam logic [PW-1:0] AF_V = PW'(AF_THRESH);
    logic [PW-1:0] free_slots;
    assign free_slots      = DEPTH_V - count;
    assign almost_full_fsm = (free_slots <= AF_V);
`else
    logic unused_af_thresh;
    assign unused_af_thresh = ^AF_THRESH;
    assign almost_full_fsm  = 1'b0;
`endif

endmodule
